// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, controller states, GF(2^8) helpers,
// S-box pair and the single-step key schedule.
package aes_pkg;

    localparam int unsigned AES_NR = 10;
    localparam int unsigned BLK_W  = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        KEYEXP  = 2'd1,
        ROUND   = 2'd2,
        OUTHOLD = 2'd3
    } aes_state_e;

    // Round constant for key-schedule step idx (1..10).
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Multiply by x modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply, shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    // Forward S-box: inverse followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine transform followed by the inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    // One key-schedule step: next 4-word round key from the previous one.
    function automatic logic [BLK_W-1:0] keystep(input logic [BLK_W-1:0] prev,
                                                 input logic [7:0]       rc);
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        t  = {sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0]), sbox(prev[31:24])}
             ^ {rc, 24'h000000};
        n0 = prev[127:96] ^ t;
        n1 = prev[95:64]  ^ n0;
        n2 = prev[63:32]  ^ n1;
        n3 = prev[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/aes_round.sv
// Single shared AES round, combinational; forward or inverse, optional final round.
module aes_round
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] state_i,
    input  logic [BLK_W-1:0] rk_i,
    input  logic             decrypt_i,
    input  logic             final_i,
    output logic [BLK_W-1:0] state_o
);

    function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] s, input logic inv);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Byte i is row i%4 of column i/4; row r rotates left by r (right when inverse).
    function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s, input logic inv);
        logic [BLK_W-1:0] o;
        int src_c;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src_c = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*src_c+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s, input logic inv);
        logic [BLK_W-1:0] o;
        logic [7:0]       a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*c+k) -: 8];
            for (int k = 0; k < 4; k++) begin
                if (inv)
                    o[127-8*(4*c+k) -: 8] = gf_mul(8'h0e, a[k])         ^ gf_mul(8'h0b, a[(k+1)%4])
                                          ^ gf_mul(8'h0d, a[(k+2)%4]) ^ gf_mul(8'h09, a[(k+3)%4]);
                else
                    o[127-8*(4*c+k) -: 8] = gf_mul(8'h02, a[k])         ^ gf_mul(8'h03, a[(k+1)%4])
                                          ^ a[(k+2)%4]                ^ a[(k+3)%4];
            end
        end
        return o;
    endfunction

    // Forward: Sub, Shift, Mix, AddKey. Inverse: InvShift, InvSub, AddKey, InvMix.
    always_comb begin
        state_o = '0;
        if (!decrypt_i) begin
            state_o = shift_rows(sub_bytes(state_i, 1'b0), 1'b0);
            if (!final_i) state_o = mix_columns(state_o, 1'b0);
            state_o = state_o ^ rk_i;
        end else begin
            state_o = sub_bytes(shift_rows(state_i, 1'b1), 1'b1) ^ rk_i;
            if (!final_i) state_o = mix_columns(state_o, 1'b1);
        end
    end

endmodule

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 controller: caches 11 round keys, one round per cycle.
module aes_iter_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR    = AES_NR,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [BLK_W-1:0] key,
    output logic             key_loaded,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_decrypt,
    input  logic [BLK_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             busy
);

    aes_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_loaded_q, key_loaded_d;
    logic             out_valid_q, out_valid_d;
    logic [BLK_W-1:0] out_data_q, out_data_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             dec_q, dec_d;
    logic [BLK_W-1:0] rk_q [0:NR];

    logic             rk_we_c;
    logic [CNT_W-1:0] rk_widx_c;
    logic [BLK_W-1:0] rk_wdata_c;
    logic [BLK_W-1:0] rnd_key_c;
    logic [BLK_W-1:0] rnd_out_c;
    logic             final_c;
    logic             key_hs_c;
    logic             in_hs_c;

    // Handshakes; a pending key always wins over a pending block.
    assign key_ready  = (state_q == IDLE) && !rst;
    assign in_ready   = key_ready && key_loaded_q && !key_valid;
    assign busy       = (state_q != IDLE);
    assign key_loaded = key_loaded_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign key_hs_c   = key_valid && key_ready;
    assign in_hs_c    = in_valid && in_ready;

    // Round key follows the counter forward for encrypt, backward for decrypt.
    assign final_c   = (cnt_q == CNT_W'(NR));
    assign rnd_key_c = dec_q ? rk_q[CNT_W'(NR) - cnt_q] : rk_q[cnt_q];

    aes_round u_round (
        .state_i   (blk_q),
        .rk_i      (rnd_key_c),
        .decrypt_i (dec_q),
        .final_i   (final_c),
        .state_o   (rnd_out_c)
    );

    // Next-state, counter, cache write and output updates.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        key_loaded_d = key_loaded_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        blk_d        = blk_q;
        dec_d        = dec_q;
        rk_we_c      = 1'b0;
        rk_widx_c    = '0;
        rk_wdata_c   = key;
        case (state_q)
            IDLE: begin
                if (key_hs_c) begin
                    rk_we_c      = 1'b1;
                    rk_widx_c    = '0;
                    rk_wdata_c   = key;
                    key_loaded_d = 1'b0;
                    cnt_d        = CNT_W'(1);
                    state_d      = KEYEXP;
                end else if (in_hs_c) begin
                    blk_d   = in_data ^ (in_decrypt ? rk_q[CNT_W'(NR)] : rk_q[CNT_W'(0)]);
                    dec_d   = in_decrypt;
                    cnt_d   = CNT_W'(1);
                    state_d = ROUND;
                end
            end
            KEYEXP: begin
                rk_we_c    = 1'b1;
                rk_widx_c  = cnt_q;
                rk_wdata_c = keystep(rk_q[cnt_q - CNT_W'(1)], rcon(4'(cnt_q)));
                if (final_c) begin
                    key_loaded_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ROUND: begin
                blk_d = rnd_out_c;
                if (final_c) begin
                    out_data_d  = rnd_out_c;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = OUTHOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OUTHOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            key_loaded_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            blk_q        <= '0;
            dec_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_loaded_q <= key_loaded_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            blk_q        <= blk_d;
            dec_q        <= dec_d;
        end
    end

    // Round-key cache; contents are qualified by key_loaded, so no reset.
    always_ff @(posedge clk) begin
        if (rk_we_c) rk_q[rk_widx_c] <= rk_wdata_c;
    end

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Bench for aes_iter_ctrl: known-answer table, handshake corner sequences,
// and random keys/blocks against an independent byte-level AES model.
module tb_aes_iter_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key = '0;
    logic         key_loaded;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_decrypt = 1'b0;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ZC  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_iter_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key        (key),
        .key_loaded (key_loaded),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_decrypt (in_decrypt),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [7:0] sb [0:255];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from walking the generator 3 and its inverse simultaneously.
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] k, input logic [127:0] pt);
        logic [7:0]   w [0:175];
        logic [7:0]   s [0:15];
        logic [7:0]   t [0:15];
        logic [7:0]   a [0:3];
        logic [7:0]   rc;
        logic [7:0]   tmp;
        logic [7:0]   all;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) a[j] = w[i-4+j];
            if (i % 16 == 0) begin
                tmp  = a[0];
                a[0] = sb[a[1]] ^ rc;
                a[1] = sb[a[2]];
                a[2] = sb[a[3]];
                a[3] = sb[tmp];
                rc   = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ a[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
                    all = a[0] ^ a[1] ^ a[2] ^ a[3];
                    for (int j = 0; j < 4; j++) s[4*c+j] = a[j] ^ all ^ xt(a[j] ^ a[(j+1)%4]);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic load_key(input logic [127:0] k);
        int n;
        logic ok;
        key       = k;
        key_valid = 1'b1;
        n = 0;
        while (!key_ready && n < 50) begin tick(); n++; end
        check("key_ready_wait", key_ready, 1);
        tick();
        key_valid = 1'b0;
        n  = 0;
        ok = 1'b1;
        while (!key_loaded && n < 30) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
            tick();
            n++;
        end
        check("keyexp_cycles", n, 10);
        check("keyexp_busy_gated", ok, 1);
    endtask

    // Accept one block and wait for its result, checking the latency.
    task automatic start_block(input logic dec, input logic [127:0] din);
        int n;
        in_decrypt = dec;
        in_data    = din;
        in_valid   = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        check("in_ready_wait", in_ready, 1);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin tick(); n++; end
        check("latency", n, 10);
    endtask

    task automatic run_block(input logic dec, input logic [127:0] din, output logic [127:0] res);
        start_block(dec, din);
        res       = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
    endtask

    typedef struct {
        logic [127:0] k;
        logic         dec;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t tv [5];

    initial begin
        logic [127:0] res;
        logic [127:0] cur_key;
        logic [127:0] rk;
        logic [127:0] rp;
        logic [127:0] rc;
        logic         have_key;
        logic         ok;
        logic         hs_in;
        logic         hs_out;
        int           n;
        int           idx;
        int           got;
        int           edge_n;
        int           acc_e [4];
        int           val_e [4];
        logic [127:0] b2b_din [4];
        logic [127:0] b2b_exp [4];

        tv[0] = '{BK,   1'b0, BP,   BC};
        tv[1] = '{C1K,  1'b1, C1C,  C1P};
        tv[2] = '{C1K,  1'b0, C1P,  C1C};
        tv[3] = '{'0,   1'b0, '0,   ZC};
        tv[4] = '{'0,   1'b1, ZC,   '0};

        build_sbox();

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_key_ready", key_ready, 0);
        check("rst_key_loaded", key_loaded, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, '0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        check("idle_key_ready", key_ready, 1);

        // Block offered with no key loaded is never accepted
        in_valid = 1'b1;
        in_data  = BP;
        ok = 1'b1;
        repeat (5) begin
            if (in_ready !== 1'b0 || busy !== 1'b0) ok = 1'b0;
            tick();
        end
        check("no_key_gate", ok, 1);
        in_valid = 1'b0;

        // Known-answer table; key reloaded only when it changes
        have_key = 1'b0;
        cur_key  = '0;
        for (int i = 0; i < 5; i++) begin
            if (!have_key || cur_key != tv[i].k) begin
                load_key(tv[i].k);
                cur_key  = tv[i].k;
                have_key = 1'b1;
            end else begin
                check("key_kept", key_loaded, 1);
            end
            run_block(tv[i].dec, tv[i].din, res);
            check($sformatf("vec%0d", i), res, tv[i].exp);
        end

        // Key and block offered together: key wins, block waits out the expansion
        key        = C1K;
        key_valid  = 1'b1;
        in_valid   = 1'b1;
        in_decrypt = 1'b1;
        in_data    = C1C;
        #1;
        check("prio_in_ready", in_ready, 0);
        check("prio_key_ready", key_ready, 1);
        tick();
        key_valid = 1'b0;
        n  = 0;
        ok = 1'b1;
        while (!key_loaded && n < 30) begin
            if (in_ready !== 1'b0) ok = 1'b0;
            tick();
            n++;
        end
        check("prio_exp_cycles", n, 10);
        check("prio_in_blocked", ok, 1);
        check("prio_in_ready_after", in_ready, 1);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin tick(); n++; end
        check("prio_latency", n, 10);
        check("prio_data", out_data, C1P);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Backpressure: result held while out_ready is low
        start_block(1'b0, C1P);
        ok = 1'b1;
        repeat (20) begin
            if (out_valid !== 1'b1 || out_data !== C1C || in_ready !== 1'b0 || key_ready !== 1'b0)
                ok = 1'b0;
            tick();
        end
        check("bp_hold", ok, 1);
        check("bp_data", out_data, C1C);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_out_valid_fall", out_valid, 0);
        check("bp_in_ready_rise", in_ready, 1);

        // Reset during round 5 of an encrypt
        in_decrypt = 1'b0;
        in_data    = BP;
        in_valid   = 1'b1;
        check("rstmid_setup", in_ready, 1);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_busy", busy, 0);
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_key_loaded", key_loaded, 0);
        ok = 1'b1;
        repeat (15) begin
            if (out_valid !== 1'b0) ok = 1'b0;
            tick();
        end
        check("rstmid_discard", ok, 1);
        load_key(BK);
        run_block(1'b0, BP, res);
        check("rstmid_reenc", res, BC);

        // Back-to-back stream with out_ready tied high
        load_key(C1K);
        b2b_din[0] = C1P; b2b_din[1] = C1C; b2b_din[2] = C1P; b2b_din[3] = C1C;
        b2b_exp[0] = C1C; b2b_exp[1] = C1P; b2b_exp[2] = C1C; b2b_exp[3] = C1P;
        for (int i = 0; i < 4; i++) begin acc_e[i] = 0; val_e[i] = 0; end
        out_ready  = 1'b1;
        idx        = 0;
        got        = 0;
        edge_n     = 0;
        in_decrypt = 1'b0;
        in_data    = b2b_din[0];
        in_valid   = 1'b1;
        for (int cyc = 0; cyc < 100 && got < 4; cyc++) begin
            hs_in  = in_valid && in_ready;
            hs_out = out_valid;
            if (hs_out) begin
                check($sformatf("b2b_data%0d", got), out_data, b2b_exp[got]);
                val_e[got] = edge_n;
                got++;
            end
            tick();
            edge_n++;
            if (hs_in && idx < 4) begin
                acc_e[idx] = edge_n;
                idx++;
                if (idx < 4) begin
                    in_decrypt = idx[0];
                    in_data    = b2b_din[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_count", got, 4);
        for (int i = 1; i < 4; i++)
            check($sformatf("b2b_period%0d", i), acc_e[i] - acc_e[i-1], 12);
        for (int i = 0; i < 4; i++)
            check($sformatf("b2b_latency%0d", i), val_e[i] - acc_e[i], 10);
        check("b2b_key_kept", key_loaded, 1);

        // Random keys and blocks against the model; decrypt must invert
        for (int t = 0; t < 5; t++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            load_key(rk);
            for (int b = 0; b < 2; b++) begin
                rp = {$urandom, $urandom, $urandom, $urandom};
                rc = model_enc(rk, rp);
                run_block(1'b0, rp, res);
                check($sformatf("rand_enc%0d_%0d", t, b), res, rc);
                run_block(1'b1, rc, res);
                check($sformatf("rand_dec%0d_%0d", t, b), res, rp);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
